// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types and helpers for the I2C master arbiter.
//   arb_state_e      : arbiter FSM states (2 bits)
//   I2C_ARB_MAX_REQ  : largest supported requester count
//   rr_pick()        : round-robin winner search starting after 'last'
package i2c_arb_pkg;

  localparam int I2C_ARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_BUSY  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  // First requester with req set, searching last+1, last+2, ... modulo nreq.
  // Returns 'last' when nothing is requesting; callers qualify with |req.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] last,
                                         input int         nreq);
    logic [2:0] pick;
    logic       found;
    int         cand;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= I2C_ARB_MAX_REQ; k++) begin
      cand = (int'(last) + k) % nreq;
      if (!found && (k <= nreq) && req[cand[2:0]]) begin
        pick  = cand[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/i2c_arb_rr.sv
// i2c_arb_rr: combinational round-robin picker.
//   req_i   : per-requester request levels
//   last_i  : index of the most recently served requester
//   idx_o   : winning requester index (valid only with valid_o)
//   valid_o : at least one requester is asking
module i2c_arb_rr
  import i2c_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      last_i,
  output logic [2:0]      idx_o,
  output logic            valid_o
);

  logic [I2C_ARB_MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext = '0;
    req_ext[NREQ-1:0] = req_i;
  end

  assign idx_o   = rr_pick(req_ext, last_i, NREQ);
  assign valid_o = |req_i;

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one I2C master between NREQ requesters, round-robin
// per transaction, and runs the master's START/END handshake for the winner.
//   iCLK, iRST_N            : clock, async active-low reset
//   req/req_*               : per-requester request level and command fields
//   gnt, done               : one-hot grant, one-cycle completion pulse
//   rsp_ack/rdata/timeout   : result of the last transaction (valid with done)
//   m_start, m_* (out)      : command to the I2C master, zero when no grant
//   m_end, m_ack, m_rdata   : status from the I2C master
// Optional build macro I2C_ARB_TIMEOUT_EN adds a watchdog of TIMEOUT_CYCLES.
//
// state | meaning
// IDLE  | no grant; pick a requester when any req is high
// START | m_start high, waiting for the master to drop m_end
// BUSY  | master working, waiting for m_end to return high
// DONE  | done pulse, grant already released; back to IDLE next cycle
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*7-1:0] req_addr,
  input  logic [NREQ-1:0]   req_wlen,
  input  logic [NREQ*8-1:0] req_wdata1,
  input  logic [NREQ*8-1:0] req_wdata2,
  input  logic [NREQ-1:0]   req_read,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              rsp_ack,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_timeout,
  output logic              m_start,
  output logic [6:0]        m_addr,
  output logic              m_wlen,
  output logic [7:0]        m_wdata1,
  output logic [7:0]        m_wdata2,
  output logic              m_read,
  input  logic              m_end,
  input  logic              m_ack,
  input  logic [7:0]        m_rdata
);

  localparam logic [1:0] ST_IDLE  = ARB_IDLE;
  localparam logic [1:0] ST_START = ARB_START;
  localparam logic [1:0] ST_BUSY  = ARB_BUSY;
  localparam logic [1:0] ST_DONE  = ARB_DONE;

  logic [1:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            m_start_q, m_start_d;
  logic            rsp_ack_q, rsp_ack_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;
  logic [2:0]      pick_idx;
  logic            pick_valid;
  logic            tmo_hit;
  logic            end_txn;

  i2c_arb_rr #(.NREQ(NREQ)) u_rr (
    .req_i   (req),
    .last_i  (last_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    m_start_d   = m_start_q;
    rsp_ack_d   = rsp_ack_q;
    rsp_rdata_d = rsp_rdata_q;
    end_txn     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          idx_d     = pick_idx;
          gnt_d     = NREQ'(1) << pick_idx;
          m_start_d = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START, ST_BUSY: begin
        // Watchdog abort wins over any handshake progress in the same cycle.
        if (tmo_hit) begin
          m_start_d   = 1'b0;
          rsp_ack_d   = 1'b1;
          rsp_rdata_d = '0;
          end_txn     = 1'b1;
        end else if (state_q == ST_START) begin
          if (!m_end) begin
            m_start_d = 1'b0;
            state_d   = ST_BUSY;
          end
        end else if (m_end) begin
          rsp_ack_d   = m_ack;
          rsp_rdata_d = m_rdata;
          end_txn     = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // gnt_q is the one-hot of idx_q, so it doubles as the done vector.
    if (end_txn) begin
      done_d  = gnt_q;
      gnt_d   = '0;
      last_d  = idx_q;
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= 3'(NREQ - 1);
      gnt_q       <= '0;
      done_q      <= '0;
      m_start_q   <= 1'b0;
      rsp_ack_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      m_start_q   <= m_start_d;
      rsp_ack_q   <= rsp_ack_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [21:0] wd_q, wd_d;
  logic        rsp_timeout_q, rsp_timeout_d;

  assign tmo_hit = ((state_q == ST_START) || (state_q == ST_BUSY)) &&
                   (wd_q == 22'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d          = wd_q;
    rsp_timeout_d = rsp_timeout_q;
    if ((state_q == ST_IDLE) && pick_valid) begin
      wd_d          = '0;
      rsp_timeout_d = 1'b0;
    end else if ((state_q == ST_START) || (state_q == ST_BUSY)) begin
      wd_d = wd_q + 22'd1;
      if (tmo_hit) rsp_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wd_q          <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  // Watchdog compiled out: the comparison is constant false for any legal limit.
  assign tmo_hit     = (TIMEOUT_CYCLES < 0);
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    m_addr   = '0;
    m_wlen   = 1'b0;
    m_wdata1 = '0;
    m_wdata2 = '0;
    m_read   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if ((gnt_q != '0) && (idx_q == 3'(i))) begin
        m_addr   = req_addr[7*i +: 7];
        m_wlen   = req_wlen[i];
        m_wdata1 = req_wdata1[8*i +: 8];
        m_wdata2 = req_wdata2[8*i +: 8];
        m_read   = req_read[i];
      end
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign m_start   = m_start_q;
  assign rsp_ack   = rsp_ack_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/i2c_arbiter.md
Name: i2c_arbiter

Overview:
- Shares the single `i2c` master (SCL/SDA to the ADV7513 and other on-board I2C slaves) between NREQ requesters.
- Requesters include the HDMI configuration sequencer, audio codec setup and runtime register pokes.
- Round-robin arbitration at transaction granularity.
- Sequences the master's START/END handshake on behalf of the granted requester and returns ACK/read data to it.

Parameters:
- NREQ, 2, number of requesters (1..8).
- TIMEOUT_CYCLES, 2_000_000, watchdog limit in iCLK cycles. Used only with I2C_ARB_TIMEOUT_EN.

Ports:
- iCLK  in  1  clock.
- iRST_N  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester transaction request; level, held until its done pulse.
- req_addr  in  NREQ*7  7-bit slave address, requester i at [7i+6:7i].
- req_wlen  in  NREQ  0 = one write byte, 1 = two write bytes.
- req_wdata1  in  NREQ*8  first write byte (sub-address).
- req_wdata2  in  NREQ*8  second write byte.
- req_read  in  NREQ  1 = read one byte after the write phase.
- gnt  out  NREQ  one-hot grant, high for the whole transaction.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- rsp_ack  out  1  master ACK status of the last transaction (1 = NACK/error); valid while any done is high.
- rsp_rdata  out  8  read byte of the last transaction; valid while any done is high.
- rsp_timeout  out  1  last transaction aborted by watchdog. Tied 0 when the feature is off.
- m_start  out  1  START to the i2c master.
- m_addr  out  7  muxed from the granted requester.
- m_wlen  out  1  muxed from the granted requester.
- m_wdata1  out  8  muxed from the granted requester.
- m_wdata2  out  8  muxed from the granted requester.
- m_read  out  1  muxed from the granted requester.
- m_end  in  1  master END; high when idle.
- m_ack  in  1  master ACK status.
- m_rdata  in  8  master read data.

Behaviour:
- Reset values:
  - state = IDLE.
  - gnt, done, m_start, rsp_ack, rsp_rdata, rsp_timeout = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 wins first.
- Outputs are registered. m_* command fields are driven from the latched grant index and are 0 when no grant is active.
- IDLE:
  - If any req is high, select the first requester with req high, searching from last+1 upward with wrap modulo NREQ.
  - Latch its index, set gnt one-hot, go to START on the next edge.
  - Decision latency is 1 cycle from req rising to gnt.
- START:
  - Assert m_start.
  - When m_end is sampled 0, go to BUSY.
- BUSY:
  - Deassert m_start.
  - When m_end is sampled 1, capture m_ack into rsp_ack and m_rdata into rsp_rdata, then go to DONE.
- DONE:
  - Pulse done[idx] for exactly 1 cycle and clear gnt.
  - Set last = idx.
  - Return to IDLE; a new grant may be issued on the following cycle.
- Minimum transaction overhead: IDLE -> gnt 1 cycle, plus 1 cycle in DONE, in addition to master time.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0.
- Requester i may not receive a second grant while another requester is pending.
- Requests are sampled only in IDLE; req changes during a transaction do not preempt it.
- If req[idx] drops mid-transaction, the transaction still completes and done[idx] still pulses.
- Requester contract: hold req and command fields stable from req rise until done; deassert req within 1 cycle of done or it is treated as a new request.
- NREQ = 1 degenerates to a pass-through sequencer with the same states.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous); m_start drops. The slave-side recovery belongs to the i2c master.

Optional Feature:
- Macro I2C_ARB_TIMEOUT_EN.
- With it:
  - 22-bit watchdog counter cleared on entry to START and incremented in START and BUSY.
  - On reaching TIMEOUT_CYCLES-1: drop m_start, set rsp_ack = 1, rsp_timeout = 1, rsp_rdata = 0, go to DONE. Normal done pulse and pointer update.
  - rsp_timeout is cleared at the next grant.
- Without it: no counter; the arbiter waits on m_end indefinitely; rsp_timeout is constant 0.

Decomposition:
- Shared package i2c_arb_pkg:
  - State enum {IDLE, START, BUSY, DONE}, 2 bits.
  - Constant I2C_ARB_MAX_REQ = 8.
  - Function rr_pick(req, last) returning the next index.
- Sub-module i2c_arb_rr: combinational round-robin picker (req, last -> idx, valid). Reusable and separately unit-testable.
- Top keeps the FSM, command mux and response registers.

Test Plan:
- Single request: NREQ=2, req[0] with addr 0x39, wdata 0x98/0x03, master model END low 10 cycles, ACK 0 -> gnt[0] one cycle after req; m_addr 0x39; one START; done[0] one cycle pulse; rsp_ack 0.
- Contention: req[0] and req[1] held constantly for 4 transactions -> grant order 0,1,0,1; exactly one done per transaction; gnt never two-hot.
- NACK and read: req[1] with read=1, master returns ACK 1, rdata 0xA5 -> rsp_ack 1 and rsp_rdata 0xA5 while done[1] is high.
- Requester drop: req[0] falls during BUSY -> transaction completes, done[0] pulses, no regrant to 0 in the next IDLE.
- Reset mid-BUSY: iRST_N low for 3 cycles -> gnt, m_start, done all 0 asynchronously; after release, req[0] wins first.
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100): master holds END low forever -> done after 100 cycles in START/BUSY, with rsp_ack 1, rsp_timeout 1, m_start 0.
